// File: rtl/mc_controller.sv
// mc_controller: multicycle Moore control unit for the ARM-subset core.
// Memory wait handshake is enabled by defining MC_MEM_WAIT_EN.
module mc_controller #(
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            Cond,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic [3:0]            ALUFlags,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  MemWrite,
  output logic                  RegWrite,
  output logic                  IRWrite,
  output logic                  AdrSrc,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  undef
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
  } state_t;

  state_t     state, state_n;
  logic [3:0] flags;
  logic       go;
  logic       cond_ex;
  logic       exec;
  logic       is_cmp, is_known, is_arith;
  logic [2:0] alu_op;
  logic       wb_en;
  logic       pcw, mw, rw, irw, und;

`ifdef MC_MEM_WAIT_EN
  assign go = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign go = 1'b1;
`endif

  // flags = {N, Z, C, V}
  always_comb begin
    cond_ex = 1'b0;
    unique case (Cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = flags[3] == flags[0];
      4'b1011: cond_ex = flags[3] != flags[0];
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    alu_op   = 3'd0;
    is_known = 1'b1;
    is_cmp   = 1'b0;
    is_arith = 1'b0;
    case (Funct[4:1])
      4'b0100: is_arith = 1'b1;
      4'b0010: begin alu_op = 3'd1; is_arith = 1'b1; end
      4'b0000: alu_op = 3'd2;
      4'b1100: alu_op = 3'd3;
      4'b0001: alu_op = 3'd4;
      4'b1111: alu_op = 3'd5;
      4'b1010: begin
        alu_op   = 3'd1;
        is_cmp   = 1'b1;
        is_arith = 1'b1;
      end
      default: is_known = 1'b0;
    endcase
  end

  assign exec = (state == EXECR) || (state == EXECI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  // CMP writes flags regardless of S; CV only move for add/sub kinds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (exec && cond_ex && (Funct[0] || is_cmp)) begin
      flags[3:2] <= ALUFlags[3:2];
      if (is_arith) flags[1:0] <= ALUFlags[1:0];
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:    if (go) state_n = DECODE;
      DECODE: begin
        unique case (Op)
          2'b00:   state_n = Funct[5] ? EXECI : EXECR;
          2'b01:   state_n = MEMADR;
          2'b10:   state_n = BRANCH;
          default: state_n = FETCH;
        endcase
      end
      MEMADR:   state_n = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  if (go) state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: if (go) state_n = FETCH;
      EXECR,
      EXECI:    state_n = is_cmp ? FETCH : ALUWB;
      ALUWB,
      BRANCH:   state_n = FETCH;
      default:  state_n = FETCH;
    endcase
  end

  // unrecognised ALU codes still run ALUWB but never write back
  assign wb_en = cond_ex & ((state != ALUWB) | is_known);

  always_comb begin
    pcw       = 1'b0;
    mw        = 1'b0;
    rw        = 1'b0;
    irw       = 1'b0;
    und       = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    unique case (state)
      FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irw       = go;
        pcw       = go;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        und       = (Op == 2'b11);
      end
      MEMADR,
      EXECI:    ALUSrcB = 2'b01;
      EXECR:    ALUSrcB = 2'b00;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mw     = cond_ex & go;
      end
      MEMWB,
      ALUWB: begin
        ResultSrc = (state == MEMWB) ? 2'b01 : 2'b00;
        if (Rd == 4'd15) pcw = wb_en;
        else             rw  = wb_en;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = cond_ex;
      end
      default: ;
    endcase
  end

  assign PCWrite    = pcw & ~reset;
  assign MemWrite   = mw & ~reset;
  assign RegWrite   = rw & ~reset;
  assign IRWrite    = irw & ~reset;
  assign undef      = und & ~reset;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01) & ~Funct[0], Op == 2'b10};
  assign ALUControl = exec ? ALU_CTRL_W'(alu_op) : '0;

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed + random instruction streams checked
// against a per-instruction reference of the control sequence.
module tb_mc_controller;
`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT = 1'b1;
`else
  localparam bit WAIT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite, MemWrite, RegWrite, IRWrite;
  logic       AdrSrc, ALUSrcA, undef;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op),
    .Funct(Funct), .Rd(Rd), .ALUFlags(ALUFlags),
    .mem_ready(mem_ready), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl), .undef(undef)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int ncyc, stalled;
  logic [3:0] flags;
  logic [3:0] ks [7] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'h1, 4'hF, 4'hA};

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask

  // ARM rule: pairs of codes share a base test, odd code inverts it
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n = f[3], z = f[2], cf = f[1], v = f[0], r;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  function automatic logic [17:0] pk(
    bit pcw, bit mw, bit rw, bit irw, bit adr, bit asa,
    logic [1:0] asb, logic [1:0] rs, logic [2:0] ac, bit und);
    logic [1:0] rsrc;
    rsrc = {(Op == 2'b01) && !Funct[0], Op == 2'b10};
    return {pcw, mw, rw, irw, adr, asa, asb, rs, Op, rsrc, ac, und};
  endfunction

  function automatic logic [17:0] obs();
    return {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
            ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, undef};
  endfunction

  // Starts at a negedge, ends at the negedge after the state advances.
  // st: forced mem_ready=0 cycles before ready, -1 for random.
  task automatic cyc(input string tag, input logic [17:0] full,
                     input logic [17:0] hold, input bit memph,
                     input int st, input logic [3:0] af);
    bit go;
    int left = st;
    forever begin
      ALUFlags = af;
      if (!memph) mem_ready = 1'($urandom);
      else if (left > 0) begin mem_ready = 1'b0; left--; end
      else if (left == 0) mem_ready = 1'b1;
      else mem_ready = ($urandom_range(3) != 0);
      go = !(WAIT && memph && !mem_ready);
      #1;
      ncyc++;
      if (!go) stalled++;
      chk(tag, obs(), go ? full : hold);
      @(negedge clk);
      if (go) break;
    end
  endtask

  task automatic run_instr(input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] af, input int sf,
                           input int sm);
    bit ce, wr, cmp, arith, known;
    logic [2:0] ac;
    logic [17:0] e, h;
    int base;
    Cond = c; Op = o; Funct = f; Rd = r;
    ncyc = 0; stalled = 0;
    ce = cond_ok(c, flags);
    e = pk(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 0, 0);
    h = pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0);
    cyc("fetch", e, h, 1, sf, 4'($urandom));
    e = pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, o == 2'b11);
    cyc("decode", e, e, 0, 0, 4'($urandom));
    if (o == 2'b11) begin
      base = 2;
    end else if (o == 2'b10) begin
      e = pk(ce, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0, 0);
      cyc("branch", e, e, 0, 0, 4'($urandom));
      base = 3;
    end else if (o == 2'b01) begin
      e = pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
      cyc("memadr", e, e, 0, 0, 4'($urandom));
      if (f[0]) begin
        e = pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        cyc("memread", e, e, 1, sm, 4'($urandom));
        e = pk(ce && r == 15, 0, ce && r != 15, 0, 0, 0,
               2'b00, 2'b01, 0, 0);
        cyc("memwb", e, e, 0, 0, 4'($urandom));
        base = 5;
      end else begin
        e = pk(0, ce, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        h = pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0);
        cyc("memwrite", e, h, 1, sm, 4'($urandom));
        base = 4;
      end
    end else begin
      cmp = (f[4:1] == 4'hA);
      arith = (f[4:1] == 4'h4) || (f[4:1] == 4'h2) || cmp;
      known = 1'b1;
      ac = 3'd0;
      case (f[4:1])
        4'h4: ac = 3'd0;
        4'h2: ac = 3'd1;
        4'h0: ac = 3'd2;
        4'hC: ac = 3'd3;
        4'h1: ac = 3'd4;
        4'hF: ac = 3'd5;
        4'hA: ac = 3'd1;
        default: known = 1'b0;
      endcase
      e = pk(0, 0, 0, 0, 0, 0, {1'b0, f[5]}, 2'b00, ac, 0);
      cyc("exec", e, e, 0, 0, af);
      if (ce && (f[0] || cmp)) begin
        flags[3:2] = af[3:2];
        if (arith) flags[1:0] = af[1:0];
      end
      if (cmp) begin
        base = 3;
      end else begin
        wr = cond_ok(c, flags) && known;
        e = pk(wr && r == 15, 0, wr && r != 15, 0, 0, 0,
               2'b00, 2'b00, 0, 0);
        cyc("aluwb", e, e, 0, 0, 4'($urandom));
        base = 4;
      end
    end
    chk("latency", ncyc, base + stalled);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c, r;
    logic [1:0] o;
    logic [5:0] f;
    logic [17:0] rv;
    reset = 1'b1;
    Cond = 4'hE; Op = 2'b00; Funct = 6'd0; Rd = 4'd0;
    ALUFlags = 4'd0; mem_ready = 1'b1;
    flags = 4'b0000;
    @(negedge clk);
    #1 chk("reset", obs(), pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0));
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    // ADDS R1,R2,R3 giving zero, then BEQ sees Z
    run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100, 0, 0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0);
    // CMP R0,R0 then BEQ
    run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0110, 0, 0);
    run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 0, 0);
    // LDR R4,[R5,#8] with NE while Z=1
    run_instr(4'h1, 2'b01, 6'b011001, 4'd4, 4'b0000, 0, 0);
    // ADD R15,R1,#4
    run_instr(4'hE, 2'b00, 6'b101000, 4'd15, 4'b0000, 0, 0);
    // STR with three wait cycles in MEMWRITE
    run_instr(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000, 0, 3);

    // reset in MEMREAD
    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
    cyc("m_fetch", pk(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 0, 0),
        pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0), 1, 0, 4'd0);
    cyc("m_decode", pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0),
        pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0), 0, 0, 4'd0);
    cyc("m_memadr", pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0),
        pk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0), 0, 0, 4'd0);
    mem_ready = 1'b1;
    #1 chk("m_memread", obs(), pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
    reset = 1'b1;
    rv = pk(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0);
    #1 chk("rst_mid", obs(), rv);
    @(posedge clk);
    #1 chk("rst_hold", obs(), rv);
    @(posedge clk);
    #2 reset = 1'b0;
    flags = 4'b0000;
    @(negedge clk);
    // undefined op, then a normal instruction
    run_instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 0, 0);
    run_instr(4'hE, 2'b00, 6'b001000, 4'd2, 4'b0000, 0, 0);

    for (int i = 0; i < 150; i++) begin
      o = 2'($urandom_range(3));
      c = ($urandom_range(1) == 0) ? 4'hE : 4'($urandom_range(15));
      f = 6'($urandom);
      if ($urandom_range(3) != 0) f[4:1] = ks[$urandom_range(6)];
      r = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom_range(14));
      run_instr(c, o, f, r, 4'($urandom), -1, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM-subset processor, the next-generation replacement for the single-cycle decoder. A Moore state machine sequences every instruction through fetch, decode, execute, memory and writeback, sharing one ALU and one memory port. Condition evaluation with registered NZCV flags, an extended ALU decoder and an optional memory wait handshake are built in. Sits between the instruction register and the multicycle datapath.

## Interface
- ALU_CTRL_W, 3, ALUControl width; must be ≥3.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20].
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  NZCV from the ALU, combinational.
- mem_ready  in  1  memory done; used only with the wait feature.
- PCWrite, MemWrite, RegWrite, IRWrite  out  1  write strobes.
- AdrSrc, ALUSrcA  out  1  datapath mux selects.
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2  datapath mux selects.
- ALUControl  out  ALU_CTRL_W  ALU operation.
- undef  out  1  one-cycle pulse when an Op=11 instruction is decoded.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECR, with Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH with undef=1.
  - MEMADR: Funct[0]=1→MEMREAD, else MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECR/EXECI→ALUWB→FETCH, except CMP, which goes EXECR/EXECI→FETCH.
  - BRANCH→FETCH.
- Moore outputs. Unlisted outputs are 0; don't-care selects are also driven 0.
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR/EXECI: ALUSrcA=0, ALUSrcB=01.
  - EXECR: ALUSrcA=0, ALUSrcB=00.
  - MEMREAD/MEMWRITE: AdrSrc=1, ResultSrc=00. MEMWRITE also asserts MemWrite=CondEx.
  - MEMWB: ResultSrc=01.
  - ALUWB: ResultSrc=00.
  - MEMWB and ALUWB, when Rd≠15: RegWrite=CondEx.
  - MEMWB and ALUWB, when Rd=15: PCWrite=CondEx, RegWrite=0.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx.
- Immediate and register selects:
  - ImmSrc=Op in every state.
  - RegSrc[0]=(Op=10).
  - RegSrc[1]=(Op=01 & Funct[0]=0), i.e. STR reads Rd.
- ALU decoder (active in EXECR/EXECI), keyed on Funct[4:1]:
  - 0100 ADD→0.
  - 0010 SUB→1.
  - 0000 AND→2.
  - 1100 ORR→3.
  - 0001 EOR→4.
  - 1111 MVN→5.
  - 1010 CMP→1, with flags always written.
  - Any other code→0, and the instruction completes with no register write.
  - All other states: ALUControl=0 (ADD). Values are zero-extended to ALU_CTRL_W.
- Flags:
  - 4-bit NZCV register.
  - In EXECR/EXECI, when CondEx and (Funct[0] or CMP): NZ are loaded.
  - CV are loaded only for ADD/SUB/CMP.
- CondEx: combinational from Cond and the registered flags.
  - Supports EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - Cond=1111 evaluates false.

## Timing
- Reset:
  - State=FETCH, flags=0000, undef=0.
  - While reset is high, PCWrite/IRWrite/RegWrite/MemWrite are forced 0; the selects show their FETCH values.
- Latency without waits:
  - B: 3 cycles.
  - CMP: 3 cycles.
  - DP and STR: 4 cycles.
  - LDR: 5 cycles.
- Flag timing: flags written in cycle N are visible to CondEx from cycle N+1. A CMP immediately followed by a conditional branch is therefore correct.
- Reset mid-instruction: abandons the instruction immediately; no strobe is issued after reset asserts. FETCH begins on the first edge after deassertion.
- A failed CondEx still takes the full state sequence, with every write strobe held 0.

## Configuration
- MC_MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - While holding, IRWrite, PCWrite and MemWrite stay low; they assert only in the cycle where mem_ready=1, and the state then advances.
  - mem_ready=1 gives zero-wait timing identical to the undefined case.
- MC_MEM_WAIT_EN undefined: mem_ready is ignored; every memory state takes one cycle.

## Test plan
- ADD R1,R2,R3 with S=1, AL, result 0 → states FETCH,DECODE,EXECR,ALUWB (4 cycles); RegWrite=1 in ALUWB; flags Z=1, C=V=0.
- CMP R0,R0 then BEQ → flags Z=1; no RegWrite in the CMP; BRANCH asserts PCWrite=1; 3+3 cycles.
- LDR R4,[R5,#8] with Cond=NE and Z=1 → 5 cycles; RegWrite=0 and PCWrite=0 in MEMWB.
- ADD R15,R1,#4 (AL) → in ALUWB, PCWrite=1 and RegWrite=0.
- With MC_MEM_WAIT_EN: STR, mem_ready=0 for 3 cycles in MEMWRITE → state held; MemWrite asserts only in the mem_ready=1 cycle; total 7 cycles.
- Reset asserted in MEMREAD → all strobes 0 at once; after release, FETCH with IRWrite=1; Op=11 decode → undef pulse of 1 cycle, return to FETCH.
